// File: rtl/cus19_lsu.sv
// cus19_lsu: splits a 19-bit LD/ST into three byte accesses (little-endian).
// Optional CUS19_LSU_WRAP_ERR_EN rejects requests that would wrap the address.
module cus19_lsu #(
  parameter int Mem_Addr_Width = 11,
  parameter int Data_Width     = 8,
  parameter int Word_Width     = 19
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      req_valid_in,
  output logic                      req_ready_out,
  input  logic                      req_wr_in,
  input  logic [Mem_Addr_Width-1:0] req_addr_in,
  input  logic [Word_Width-1:0]     req_wdata_in,
  output logic                      resp_valid_out,
  output logic [Word_Width-1:0]     resp_rdata_out,
  output logic                      resp_err_out,
  output logic                      busy_out,
  output logic                      mem_rd_out,
  output logic [Mem_Addr_Width-1:0] mem_rd_addr_out,
  input  logic [Data_Width-1:0]     mem_rd_data_in,
  output logic                      mem_wr_out,
  output logic [Mem_Addr_Width-1:0] mem_wr_addr_out,
  output logic [Data_Width-1:0]     mem_wr_data_out
);

  localparam int HiW = Word_Width - 2 * Data_Width;

  typedef enum logic [2:0] {
    IDLE,
    B0,
    B1,
    B2,
    RESP
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [Mem_Addr_Width-1:0] r_addr;
  logic                      r_wr;
  logic [Word_Width-1:0]     r_wdata;
  logic [Word_Width-1:0]     r_rdata;
  logic                      w_accept;
  logic                      w_err;
  logic                      w_in_byte;
  logic [1:0]                w_idx;
  logic [Mem_Addr_Width-1:0] w_addr;
  logic [Data_Width-1:0]     w_wbyte;
  logic                      w_unused;

  assign w_unused = &{1'b0, mem_rd_data_in[Data_Width-1:HiW]};
  assign w_accept = req_valid_in & (r_state == IDLE);

`ifdef CUS19_LSU_WRAP_ERR_EN
  localparam logic [Mem_Addr_Width-1:0] AddrLim =
    {{(Mem_Addr_Width-2){1'b1}}, 2'b01};

  logic r_err;

  assign w_err = req_addr_in > AddrLim;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_err;
    end
  end

  assign resp_err_out = (r_state == RESP) & r_err;
`else
  assign w_err        = 1'b0;
  assign resp_err_out = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = w_err ? RESP : B0;
      B0:      w_next = B1;
      B1:      w_next = B2;
      B2:      w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= req_addr_in;
        r_wr    <= req_wr_in;
        r_wdata <= req_wdata_in;
        r_rdata <= '0;
      end
      // Read port is combinational: byte is valid in its own Bk cycle
      if (!r_wr) begin
        unique case (r_state)
          B0: r_rdata[Data_Width-1:0] <= mem_rd_data_in;
          B1: r_rdata[2*Data_Width-1:Data_Width] <= mem_rd_data_in;
          B2: r_rdata[Word_Width-1:2*Data_Width] <= mem_rd_data_in[HiW-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_in_byte = 1'b0;
    w_idx     = 2'd0;
    w_wbyte   = '0;
    unique case (r_state)
      B0: begin
        w_in_byte = 1'b1;
        w_idx     = 2'd0;
        w_wbyte   = r_wdata[Data_Width-1:0];
      end
      B1: begin
        w_in_byte = 1'b1;
        w_idx     = 2'd1;
        w_wbyte   = r_wdata[2*Data_Width-1:Data_Width];
      end
      B2: begin
        w_in_byte = 1'b1;
        w_idx     = 2'd2;
        w_wbyte   = {{(Data_Width-HiW){1'b0}},
                     r_wdata[Word_Width-1:2*Data_Width]};
      end
      default: ;
    endcase
  end

  assign w_addr = r_addr + {{(Mem_Addr_Width-2){1'b0}}, w_idx};

  assign mem_rd_out      = w_in_byte & ~r_wr;
  assign mem_rd_addr_out = mem_rd_out ? w_addr : '0;
  assign mem_wr_out      = w_in_byte & r_wr;
  assign mem_wr_addr_out = mem_wr_out ? w_addr : '0;
  assign mem_wr_data_out = mem_wr_out ? w_wbyte : '0;

  assign req_ready_out  = (r_state == IDLE);
  assign busy_out       = (r_state != IDLE);
  assign resp_valid_out = (r_state == RESP);
  assign resp_rdata_out = (resp_valid_out & ~r_wr) ? r_rdata : '0;

endmodule
